counter_up_down: RTL and testbench
==================================

COUNTER_UP_DOWN -- requirements
Module: counter_up_down

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 Parameter RESET_VAL, default 0, value loaded into count on reset (truncated to WIDTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; 1 = step this cycle, 0 = hold.
REQ-006 up_down  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 count  output  WIDTH  registered counter value.
REQ-010 tc  output  1  terminal count, combinational: next enabled step reaches or crosses the bound in the current direction.
REQ-011 zero  output  1  combinational; 1 when count == 0.

Function
REQ-012 Priority at each rising clk edge SHALL be rst > load > en > hold.
REQ-013 With load=1 and rst=0, count SHALL take d on the next edge regardless of en and up_down.
REQ-014 With en=1, load=0 and up_down=1, count SHALL become count+1 (modulo 2^WIDTH) on the next edge.
REQ-015 With en=1, load=0 and up_down=0, count SHALL become count-1 (modulo 2^WIDTH) on the next edge.
REQ-016 With en=0, load=0 and rst=0, count SHALL hold its value.
REQ-017 Latency SHALL be one cycle from input sampling to the updated count; there is no pipelining.
REQ-018 Default wrap-around SHALL be 2^WIDTH-1 -> 0 counting up and 0 -> 2^WIDTH-1 counting down.
REQ-019 tc SHALL be 1 when en=1 and either (up_down=1 and count=2^WIDTH-1) or (up_down=0 and count=0); otherwise 0.
REQ-020 A change of up_down mid-count SHALL take effect on the very next enabled edge, with no skipped or repeated values.
REQ-021 tc and zero SHALL be glitch-tolerant combinational decodes of the registered count and inputs; no extra register stage.

Reset
REQ-022 When rst=1 at a rising edge, count SHALL become RESET_VAL on that edge, overriding load and en.
REQ-023 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume from RESET_VAL on the first edge after rst deasserts.
REQ-024 After reset, zero SHALL equal (RESET_VAL == 0) and tc SHALL follow REQ-019.

Configuration
REQ-025 Macro COUNTER_UP_DOWN_SAT_EN SHALL select saturating mode when defined.
REQ-026 With COUNTER_UP_DOWN_SAT_EN defined, count SHALL hold at 2^WIDTH-1 when counting up and at 0 when counting down, and tc SHALL remain asserted while held at the bound in the active direction.
REQ-027 Without COUNTER_UP_DOWN_SAT_EN, the wrap-around behaviour of REQ-018 SHALL apply.
REQ-028 Load and reset behaviour SHALL be identical in both modes.

Verification (WIDTH=8, RESET_VAL=0)
REQ-029 rst=1 for 1 edge, then en=1 and up_down=1 for 70 edges -> count=70, zero=0.
REQ-030 From count=70, set up_down=0 for 100 edges -> count=226 in wrap mode (passing through 0 with zero=1 and tc=1 at count=0); count=0 held with tc=1 in saturating mode.
REQ-031 load=1 with d=8'hFE, then up for 3 edges -> count sequence 254, 255, 0, 1 (wrap) or 254, 255, 255, 255 (saturating); tc=1 while count=255.
REQ-032 rst=1 together with load=1 and en=1 mid-count -> count=0 on the next edge.
REQ-033 en=0 for 10 edges while toggling up_down -> count unchanged and tc=0.

Source files
------------

// File: rtl/counter_up_down.sv
// Up/down counter with synchronous load and reset; count updates one cycle after inputs are sampled.
// Define COUNTER_UP_DOWN_SAT_EN for saturating mode (count sticks at the bounds); default build wraps.
module counter_up_down #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic at_max;
    logic at_min;

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= d;
        end else if (en) begin
`ifdef COUNTER_UP_DOWN_SAT_EN
            // Saturating: a step that would cross a bound leaves count where it is.
            if (up_down && !at_max) begin
                count <= count + 1'b1;
            end else if (!up_down && !at_min) begin
                count <= count - 1'b1;
            end
`else
            if (up_down) begin
                count <= count + 1'b1;
            end else begin
                count <= count - 1'b1;
            end
`endif
        end
    end

    // tc stays high while parked at a bound in saturating mode, since the same decode still holds.
    assign tc   = en && (up_down ? at_max : at_min);
    assign zero = at_min;

endmodule

// File: tb/tb_counter_up_down.sv
// Bench for counter_up_down (WIDTH=8, RESET_VAL=0): vector table, directed corner sequences, random vs arithmetic model.
module tb_counter_up_down;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] d;
    logic [7:0] count;
    logic       tc;
    logic       zero;

`ifdef COUNTER_UP_DOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    counter_up_down #(.WIDTH(8), .RESET_VAL(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up_down (up_down),
        .load    (load),
        .d       (d),
        .count   (count),
        .tc      (tc),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m       = 0;

    typedef struct {
        bit       rst;
        bit       load;
        bit       en;
        bit       up_down;
        bit [7:0] d;
        int       exp_count;
        bit       exp_tc;
        bit       exp_zero;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference rules written as plain arithmetic on integers.
    function automatic int model_next(input int c, input bit r, input bit l, input bit e,
                                      input bit u, input int dv);
        if (r) return 0;
        if (l) return dv;
        if (!e) return c;
        if (SAT) return u ? ((c == 255) ? 255 : c + 1) : ((c == 0) ? 0 : c - 1);
        return u ? (c + 1) % 256 : (c + 255) % 256;
    endfunction

    function automatic bit model_tc(input int c, input bit e, input bit u);
        return e && ((u && c == 255) || (!u && c == 0));
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit r, input bit l, input bit e, input bit u,
                         input logic [7:0] dv, input string tag);
        rst = r; load = l; en = e; up_down = u; d = dv;
        #1;
        check({tag, "_tc"}, int'(tc), int'(model_tc(m, e, u)));
        check({tag, "_zero"}, int'(zero), int'(m == 0));
        @(posedge clk);
        m = model_next(m, r, l, e, u, int'(dv));
        #1;
        check({tag, "_count"}, int'(count), m);
        @(negedge clk);
    endtask

    vec_t vecs[13];
    int   exp_seq[4];
    int   held;

    initial begin
        // Vectors run from count=0 and stay clear of the mode-dependent wrap/saturate steps.
        vecs[0]  = '{0, 0, 1, 1, 8'h00, 8'h01, 0, 1};
        vecs[1]  = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 8'h80, 8'h80, 1, 1};
        vecs[3]  = '{0, 0, 1, 1, 8'h00, 8'h81, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 8'h00, 8'h81, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 8'h7F, 8'h7F, 0, 0};
        vecs[6]  = '{0, 0, 1, 0, 8'h00, 8'h7E, 0, 0};
        vecs[7]  = '{1, 1, 1, 1, 8'h55, 8'h00, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 8'hFF, 8'hFF, 0, 1};
        vecs[10] = '{0, 0, 1, 0, 8'h00, 8'hFE, 0, 0};
        vecs[11] = '{0, 0, 1, 1, 8'h00, 8'hFF, 0, 0};
        vecs[12] = '{0, 1, 1, 1, 8'h10, 8'h10, 1, 0};

        rst = 1'b1; load = 1'b0; en = 1'b0; up_down = 1'b0; d = 8'h00;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_count", int'(count), 0);
        check("reset_zero", int'(zero), 1);
        check("reset_tc", int'(tc), 0);
        m = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; load = vecs[i].load; en = vecs[i].en;
            up_down = vecs[i].up_down; d = vecs[i].d;
            #1;
            check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].exp_tc));
            check($sformatf("vec%0d_zero", i), int'(zero), int'(vecs[i].exp_zero));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            m = vecs[i].exp_count;
            @(negedge clk);
        end

        // Reset for one edge, then count up 70.
        cycle(1, 0, 0, 0, 8'h00, "seq_rst");
        for (int i = 0; i < 70; i++) cycle(0, 0, 1, 1, 8'h00, "seq_up70");
        check("up70_count", int'(count), 70);
        check("up70_zero", int'(zero), 0);

        // Down 100 from 70: wraps through 0 or parks at 0.
        for (int i = 0; i < 100; i++) cycle(0, 0, 1, 0, 8'h00, "seq_down100");
        check("down100_count", int'(count), SAT ? 0 : 226);
        #1;
        check("down100_tc", int'(tc), SAT ? 1 : 0);

        // Load 0xFE then step up across the top bound.
        if (SAT) begin
            exp_seq[0] = 254; exp_seq[1] = 255; exp_seq[2] = 255; exp_seq[3] = 255;
        end else begin
            exp_seq[0] = 254; exp_seq[1] = 255; exp_seq[2] = 0;   exp_seq[3] = 1;
        end
        cycle(0, 1, 0, 0, 8'hFE, "seq_load");
        check("load_seq0", int'(count), exp_seq[0]);
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 1, 1, 8'h00, "seq_up3");
            check($sformatf("load_seq%0d", i), int'(count), exp_seq[i]);
        end

        // Reset beats load and en mid-count.
        cycle(0, 1, 0, 0, 8'h42, "seq_preload");
        cycle(1, 1, 1, 1, 8'hAA, "seq_rst_prio");
        check("rst_prio_count", int'(count), 0);

        // Hold for 10 edges while up_down toggles.
        cycle(0, 1, 0, 0, 8'h37, "seq_hold_load");
        held = int'(count);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, i[0], 8'h00, "seq_hold");
        check("hold_count", int'(count), held);
        check("hold_value", held, 8'h37);

        // Direction flip takes effect on the very next enabled edge.
        cycle(0, 0, 1, 1, 8'h00, "seq_flip_up");
        cycle(0, 0, 1, 0, 8'h00, "seq_flip_dn");
        check("flip_count", int'(count), 8'h37);

        // Random stimulus, biased so loads often land near the bounds.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] dv;
            case ($urandom_range(0, 3))
                0: dv = 8'h00;
                1: dv = 8'hFF;
                2: dv = 8'(($urandom_range(0, 1) != 0) ? 1 : 254);
                default: dv = 8'($urandom_range(0, 255));
            endcase
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, dv, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
